// File: rtl/vect_pkg.sv
// vect_pkg: shared vector-unit types for decode, sequencing and lanes.
package vect_pkg;
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] vd;
        logic [3:0] vs1;
        logic [3:0] vs2;
    } arithm_instr_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} seq_state_t;
endpackage

// File: rtl/lane_sequencer_if.sv
// lane_sequencer_if: front-end instruction handshake plus lane broadcast/completion bundle.
interface lane_sequencer_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    import vect_pkg::*;
    logic              instr_valid_i;
    arithm_instr_t     instr_i;
    logic              instr_ready_o;
    logic              lane_instr_req_o;
    arithm_instr_t     lane_instr_o;
    logic [LANES-1:0]  lane_ready_i;
    logic              busy_o;
    logic              retired_o;
    logic [CNT_W-1:0]  retire_cnt_o;
    logic              err_o;

    modport slave (
        input  instr_valid_i, instr_i, lane_ready_i,
        output instr_ready_o, lane_instr_req_o, lane_instr_o, busy_o, retired_o, retire_cnt_o, err_o
    );
    modport master (
        output instr_valid_i, instr_i, lane_ready_i,
        input  instr_ready_o, lane_instr_req_o, lane_instr_o, busy_o, retired_o, retire_cnt_o, err_o
    );
endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with registered occupancy and a combinational head.
module instr_fifo
    import vect_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = arithm_instr_t
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rd];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr <= wr + AW'(1);
            if (do_pop) rd <= rd + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/lane_sequencer.sv
// lane_sequencer: broadcasts queued instructions to all lanes and retires each once every lane reports done.
module lane_sequencer
    import vect_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic             clk_i,
    input logic             resetn_i,
    lane_sequencer_if.slave bus
);
    seq_state_t       state;
    logic [LANES-1:0] done_q;
    logic             push, pop, full, empty, all_done;
    arithm_instr_t    head;

    assign push     = bus.instr_valid_i && !full;
    assign pop      = state == ST_ISSUE;
    assign all_done = &(done_q | bus.lane_ready_i);

    assign bus.instr_ready_o    = !full;
    assign bus.lane_instr_req_o = state == ST_ISSUE;
    assign bus.lane_instr_o     = head;
    assign bus.busy_o           = state != ST_IDLE || !empty;
    assign bus.retired_o        = state == ST_WAIT && all_done;

    instr_fifo #(.DEPTH(DEPTH), .T(arithm_instr_t)) u_fifo (
        .clk    (clk_i),
        .resetn (resetn_i),
        .push   (push),
        .pop    (pop),
        .din    (bus.instr_i),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state            <= ST_IDLE;
            done_q           <= '0;
            bus.retire_cnt_o <= '0;
            bus.err_o        <= 1'b0;
        end else begin
            // stray pulses outside WAIT and repeat pulses within WAIT are flagged, never accumulated
            if (state != ST_WAIT ? |bus.lane_ready_i : |(done_q & bus.lane_ready_i)) bus.err_o <= 1'b1;
            case (state)
                ST_IDLE:  if (!empty) state <= ST_ISSUE;
                ST_ISSUE: begin
                    done_q <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    done_q <= done_q | bus.lane_ready_i;
                    if (all_done) begin
                        bus.retire_cnt_o <= bus.retire_cnt_o + CNT_W'(1);
                        state            <= (!empty || push) ? ST_ISSUE : ST_IDLE;
                    end
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lane_sequencer.sv
// tb_lane_sequencer: directed checks of issue, skew, backpressure, errors and reset.
module tb_lane_sequencer;
    import vect_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    lane_sequencer_if #(.LANES(4), .CNT_W(16)) bus ();
    lane_sequencer #(.LANES(4), .DEPTH(4), .CNT_W(16)) dut (.clk_i(clk), .resetn_i(resetn), .bus(bus));

    int checks = 0;
    int errors = 0;
    arithm_instr_t z, ia, ib, id, ie, i_f, ig, ih;
    arithm_instr_t cq [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input arithm_instr_t i, input logic [3:0] l);
        @(posedge clk);
        #1;
        bus.instr_valid_i = v;
        bus.instr_i       = i;
        bus.lane_ready_i  = l;
        #1;
    endtask

    initial begin
        z  = '0;
        ia = 16'hA123; ib = 16'hB456; id = 16'hD789; ie = 16'hE0E1;
        i_f = 16'hF00F; ig = 16'h1111; ih = 16'h2222;
        cq[0] = 16'hC000; cq[1] = 16'hC101; cq[2] = 16'hC202; cq[3] = 16'hC303; cq[4] = 16'hC404;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.lane_ready_i  = '0;
        step(1'b0, z, 4'h0);
        step(1'b0, z, 4'h0);
        chk("rst_ready", 32'(bus.instr_ready_o), 1);
        chk("rst_req", 32'(bus.lane_instr_req_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_retired", 32'(bus.retired_o), 0);
        chk("rst_cnt", 32'(bus.retire_cnt_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        resetn = 1'b1;

        // single issue, all lanes together 6 cycles after the request
        step(1'b1, ia, 4'h0);
        chk("s_ready", 32'(bus.instr_ready_o), 1);
        step(1'b0, z, 4'h0);
        chk("s_req_t1", 32'(bus.lane_instr_req_o), 0);
        chk("s_busy_t1", 32'(bus.busy_o), 1);
        step(1'b0, z, 4'h0);
        chk("s_req_t2", 32'(bus.lane_instr_req_o), 1);
        chk("s_instr", 32'(bus.lane_instr_o), 32'(ia));
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, z, 4'h0);
            chk("s_wait_ret", 32'(bus.retired_o), 0);
            chk("s_wait_req", 32'(bus.lane_instr_req_o), 0);
        end
        step(1'b0, z, 4'hF);
        chk("s_retired", 32'(bus.retired_o), 1);
        step(1'b0, z, 4'h0);
        chk("s_ret_low", 32'(bus.retired_o), 0);
        chk("s_cnt", 32'(bus.retire_cnt_o), 1);
        chk("s_busy_end", 32'(bus.busy_o), 0);

        // skewed lanes: 0 at +3, 1 at +5, 2 and 3 at +9
        step(1'b1, ib, 4'h0);
        step(1'b0, z, 4'h0);
        step(1'b0, z, 4'h0);
        chk("k_req", 32'(bus.lane_instr_req_o), 1);
        chk("k_instr", 32'(bus.lane_instr_o), 32'(ib));
        for (int i = 1; i <= 9; i++) begin
            logic [3:0] l;
            l = (i == 3) ? 4'h1 : (i == 5) ? 4'h2 : (i == 9) ? 4'hC : 4'h0;
            step(1'b0, z, l);
            chk("k_retired", 32'(bus.retired_o), (i == 9) ? 1 : 0);
        end
        step(1'b0, z, 4'h0);
        chk("k_cnt", 32'(bus.retire_cnt_o), 2);
        chk("k_err", 32'(bus.err_o), 0);
        chk("k_busy", 32'(bus.busy_o), 0);

        // fill the FIFO behind a waiting instruction, then push against full across ISSUE
        step(1'b1, id, 4'h0);
        step(1'b0, z, 4'h0);
        step(1'b0, z, 4'h0);
        chk("b_req_d", 32'(bus.lane_instr_req_o), 1);
        chk("b_instr_d", 32'(bus.lane_instr_o), 32'(id));
        for (int k = 0; k < 4; k++) begin
            step(1'b1, cq[k], 4'h0);
            chk("b_ready_fill", 32'(bus.instr_ready_o), 1);
        end
        step(1'b1, cq[4], 4'h0);
        chk("b_full", 32'(bus.instr_ready_o), 0);
        chk("b_no_ret", 32'(bus.retired_o), 0);
        step(1'b1, cq[4], 4'hF);
        chk("b_full_ret", 32'(bus.instr_ready_o), 0);
        chk("b_ret_d", 32'(bus.retired_o), 1);
        step(1'b1, cq[4], 4'h0);
        chk("b_issue_c0", 32'(bus.lane_instr_req_o), 1);
        chk("b_instr_c0", 32'(bus.lane_instr_o), 32'(cq[0]));
        chk("b_refused", 32'(bus.instr_ready_o), 0);
        step(1'b1, cq[4], 4'h0);
        chk("b_accept", 32'(bus.instr_ready_o), 1);
        chk("b_req_low", 32'(bus.lane_instr_req_o), 0);
        step(1'b0, z, 4'hF);
        chk("b_full_again", 32'(bus.instr_ready_o), 0);
        chk("b_ret_c0", 32'(bus.retired_o), 1);
        for (int k = 1; k < 5; k++) begin
            step(1'b0, z, 4'h0);
            chk("b_issue", 32'(bus.lane_instr_req_o), 1);
            chk("b_order", 32'(bus.lane_instr_o), 32'(cq[k]));
            step(1'b0, z, 4'hF);
            chk("b_ret", 32'(bus.retired_o), 1);
        end
        step(1'b0, z, 4'h0);
        chk("b_cnt", 32'(bus.retire_cnt_o), 8);
        chk("b_busy", 32'(bus.busy_o), 0);
        chk("b_err", 32'(bus.err_o), 0);

        // stray pulse while idle
        step(1'b0, z, 4'h4);
        chk("e_pre", 32'(bus.err_o), 0);
        step(1'b0, z, 4'h0);
        chk("e_idle", 32'(bus.err_o), 1);
        step(1'b0, z, 4'h0);
        chk("e_sticky", 32'(bus.err_o), 1);

        // reset mid-WAIT with two lanes done and two instructions queued
        step(1'b1, i_f, 4'h0);
        step(1'b0, z, 4'h0);
        step(1'b0, z, 4'h0);
        chk("r_req", 32'(bus.lane_instr_req_o), 1);
        step(1'b1, ig, 4'h3);
        chk("r_no_ret1", 32'(bus.retired_o), 0);
        step(1'b1, ih, 4'h0);
        chk("r_busy", 32'(bus.busy_o), 1);
        step(1'b0, z, 4'h0);
        resetn = 1'b0;
        #1;
        chk("r_no_ret2", 32'(bus.retired_o), 0);
        step(1'b0, z, 4'h0);
        resetn = 1'b1;
        chk("r_ready", 32'(bus.instr_ready_o), 1);
        chk("r_req0", 32'(bus.lane_instr_req_o), 0);
        chk("r_busy0", 32'(bus.busy_o), 0);
        chk("r_ret0", 32'(bus.retired_o), 0);
        chk("r_cnt0", 32'(bus.retire_cnt_o), 0);
        chk("r_err0", 32'(bus.err_o), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, z, 4'h0);
            chk("r_lost_req", 32'(bus.lane_instr_req_o), 0);
            chk("r_lost_busy", 32'(bus.busy_o), 0);
        end

        // duplicate pulse in WAIT still lets the instruction retire
        step(1'b1, ie, 4'h0);
        step(1'b0, z, 4'h0);
        step(1'b0, z, 4'h0);
        chk("d_req", 32'(bus.lane_instr_req_o), 1);
        chk("d_instr", 32'(bus.lane_instr_o), 32'(ie));
        step(1'b0, z, 4'h2);
        chk("d_err0", 32'(bus.err_o), 0);
        chk("d_ret0", 32'(bus.retired_o), 0);
        step(1'b0, z, 4'h2);
        chk("d_err_pend", 32'(bus.err_o), 0);
        chk("d_ret1", 32'(bus.retired_o), 0);
        step(1'b0, z, 4'hD);
        chk("d_err", 32'(bus.err_o), 1);
        chk("d_ret", 32'(bus.retired_o), 1);
        step(1'b0, z, 4'h0);
        chk("d_cnt", 32'(bus.retire_cnt_o), 1);
        chk("d_busy", 32'(bus.busy_o), 0);
        chk("d_err_sticky", 32'(bus.err_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
